// File: rtl/updi_uart_rx.sv
// updi_uart_rx - UPDI single-wire receive front end.
//
// Oversamples the idle-high UPDI line and deframes 8E2 characters
// (start, 8 data LSB-first, even parity, 2 stop). Good bytes are written
// to the input FIFO; parity/framing/overflow/BREAK are one-cycle pulses.
//
// Optional feature macro: UPDI_RX_BREAK_DETECT_EN
//   defined   : an all-zero frame with low STOP1 is a BREAK; break_det pulses
//               once the line returns high, and no frame_err is raised.
//   undefined : break_det is tied low; a BREAK is an ordinary framing error.
//
// Ports:
//   clk            system clock, all state on posedge
//   rst            asynchronous active-low reset
//   rx             raw UPDI line (idle high, asynchronous)
//   rx_en          receiver enable; low aborts any frame in progress
//   rx_data        received byte, valid with rx_fifo_wr_en
//   rx_fifo_wr_en  one-cycle FIFO write strobe
//   rx_fifo_full   FIFO full flag, sampled at the STOP2 sample point
//   parity_err     one-cycle pulse, parity mismatch (byte dropped)
//   frame_err      one-cycle pulse, stop bit low (byte dropped)
//   overflow       one-cycle pulse, good byte dropped due to full FIFO
//   break_det      one-cycle pulse, BREAK ended
module updi_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_fifo_wr_en,
  input  logic       rx_fifo_full,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       break_det
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic          meta_q, rxs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;      // running XOR; after PARITY, 1 = bad parity
  logic          wr_q, wr_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic          sample;
`ifdef UPDI_RX_BREAK_DETECT_EN
  logic          pbit_q, pbit_d;
  logic          brk_pend_q, brk_pend_d;
  logic          brk_q, brk_d;
`endif

  assign sample = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    wr_d    = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    ovf_d   = 1'b0;
`ifdef UPDI_RX_BREAK_DETECT_EN
    pbit_d     = pbit_q;
    brk_pend_d = brk_pend_q;
    brk_d      = 1'b0;
`endif

    if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} && !sample)
      cnt_d = cnt_q - 1'b1;

    if (state_q != S_IDLE && !rx_en) begin
      // Abort: drop the partial byte so rx_data shows its reset value again.
      state_d = S_IDLE;
      shift_d = '0;
`ifdef UPDI_RX_BREAK_DETECT_EN
      brk_pend_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q && rx_en) begin
            state_d = S_START;
            cnt_d   = HALF_M1;
          end
        end
        S_START: begin
          if (sample) begin
            cnt_d = FULL_M1;
            idx_d = '0;
            par_d = 1'b0;
            state_d = rxs_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (sample) begin
            cnt_d   = FULL_M1;
            shift_d = {rxs_q, shift_q[7:1]};
            par_d   = par_q ^ rxs_q;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          if (sample) begin
            cnt_d   = FULL_M1;
            par_d   = par_q ^ rxs_q;
`ifdef UPDI_RX_BREAK_DETECT_EN
            pbit_d  = rxs_q;
`endif
            state_d = S_STOP1;
          end
        end
        S_STOP1: begin
          if (sample) begin
            cnt_d = FULL_M1;
            if (rxs_q) begin
              state_d = S_STOP2;
            end else begin
              state_d = S_WAIT_HIGH;
`ifdef UPDI_RX_BREAK_DETECT_EN
              if (shift_q == '0 && !pbit_q) brk_pend_d = 1'b1;
              else                          ferr_d     = 1'b1;
`else
              ferr_d = 1'b1;
`endif
            end
          end
        end
        S_STOP2: begin
          if (sample) begin
            state_d = S_IDLE;
            if (!rxs_q)            ferr_d = 1'b1;
            else if (par_q)        perr_d = 1'b1;
            else if (rx_fifo_full) ovf_d  = 1'b1;
            else                   wr_d   = 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs_q) begin
            state_d = S_IDLE;
`ifdef UPDI_RX_BREAK_DETECT_EN
            brk_d      = brk_pend_q;
            brk_pend_d = 1'b0;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      wr_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      meta_q  <= rx;
      rxs_q   <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      wr_q    <= wr_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef UPDI_RX_BREAK_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pbit_q     <= 1'b0;
      brk_pend_q <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      pbit_q     <= pbit_d;
      brk_pend_q <= brk_pend_d;
      brk_q      <= brk_d;
    end
  end
  assign break_det = brk_q;
`else
  assign break_det = 1'b0;
`endif

  assign rx_data       = shift_q;
  assign rx_fifo_wr_en = wr_q;
  assign parity_err    = perr_q;
  assign frame_err     = ferr_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_updi_uart_rx.sv
// Testbench for updi_uart_rx: directed frames, expected strobes predicted
// from frame contents and line timing, checked every cycle.
module tb_updi_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
  localparam logic [4:0] EV_WR   = 5'b10000;
  localparam logic [4:0] EV_PERR = 5'b01000;
  localparam logic [4:0] EV_FERR = 5'b00100;
  localparam logic [4:0] EV_OVF  = 5'b00010;
  localparam logic [4:0] EV_BRK  = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_en = 1'b1;
  logic       rx_fifo_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_fifo_wr_en, parity_err, frame_err, overflow, break_det;

  updi_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_en(rx_en),
    .rx_data(rx_data), .rx_fifo_wr_en(rx_fifo_wr_en),
    .rx_fifo_full(rx_fifo_full), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow), .break_det(break_det)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [4:0] exp_ev  [int];
  logic [7:0] exp_dat [int];
  logic [7:0] got_q [$];
  int n_perr = 0, n_ferr = 0, n_ovf = 0, n_brk = 0;
  int n_first = -1;
  int first_wr_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe for the sample of frame bit k (0..7 data, 8 parity, 9/10 stop)
  // appears: 2 cycles synchroniser, half bit to start check, (k+1) bits, +1 register.
  function automatic int strobe_cyc(input int n, input int k);
    return n + 2 + H + (k + 1) * C + 1;
  endfunction

  task automatic expect_ev(input int at, input logic [4:0] ev, input logic [7:0] d);
    exp_ev[at]  = ev;
    exp_dat[at] = d;
  endtask

  task automatic compare_cycle();
    logic [4:0] e, a;
    e = exp_ev.exists(cyc) ? exp_ev[cyc] : 5'b0;
    a = {rx_fifo_wr_en, parity_err, frame_err, overflow, break_det};
    chk($sformatf("strobes@%0d", cyc), {27'b0, a}, {27'b0, e});
    if (e == EV_WR)
      chk($sformatf("rx_data@%0d", cyc), {24'b0, rx_data}, {24'b0, exp_dat[cyc]});
    if (rx_fifo_wr_en) begin
      got_q.push_back(rx_data);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
    n_perr += int'(parity_err);
    n_ferr += int'(frame_err);
    n_ovf  += int'(overflow);
    n_brk  += int'(break_det);
  endtask

  // Starts at the current cycle and leaves time #1 after the posedge that
  // ends the second stop bit, so calls chain with zero idle time.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                            input logic s2, input logic full, input int abort_bit,
                            input logic use_rst);
    logic [11:0] bits;
    int n;
    bits = {s2, s1, p, d, 1'b0};
    n = cyc;
    if (n_first < 0) n_first = n;
    rx_fifo_full = full;
    if (abort_bit < 0) begin
      if (!s1) begin
`ifdef UPDI_RX_BREAK_DETECT_EN
        if (!(d == 8'h00 && !p)) expect_ev(strobe_cyc(n, 9), EV_FERR, 8'h00);
`else
        expect_ev(strobe_cyc(n, 9), EV_FERR, 8'h00);
`endif
      end else if (!s2)     expect_ev(strobe_cyc(n, 10), EV_FERR, 8'h00);
      else if ((^d) ^ p)    expect_ev(strobe_cyc(n, 10), EV_PERR, 8'h00);
      else if (full)        expect_ev(strobe_cyc(n, 10), EV_OVF, 8'h00);
      else                  expect_ev(strobe_cyc(n, 10), EV_WR, d);
    end
    for (int b = 0; b < 12; b++) begin
      rx = bits[b];
      for (int c = 0; c < C; c++) begin
        if (b == abort_bit && c == 8) begin
          if (use_rst) rst = 1'b0;
          else         rx_en = 1'b0;
        end
        tick();
      end
    end
    rx_fifo_full = 1'b0;
    if (abort_bit >= 0) begin
      chk(use_rst ? "rx_data_in_reset" : "rx_data_after_abort", {24'b0, rx_data}, 32'h0);
      rst   = 1'b1;
      rx_en = 1'b1;
    end
  endtask

  task automatic idle(input int m);
    rx = 1'b1;
    repeat (m) tick();
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) tick();
    rx = 1'b1;
  endtask

  task automatic hold_low(input int nbits);
    int n;
    n = cyc;
`ifdef UPDI_RX_BREAK_DETECT_EN
    expect_ev(n + nbits * C + 3, EV_BRK, 8'h00);
`else
    expect_ev(strobe_cyc(n, 9), EV_FERR, 8'h00);
`endif
    rx = 1'b0;
    repeat (nbits * C) tick();
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_bytes [7];
    exp_bytes = '{8'h55, 8'hF0, 8'h01, 8'hF1, 8'hA5, 8'h13, 8'h7E};

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (3) tick();
    chk("reset_rx_data", {24'b0, rx_data}, 32'h0);
    chk("reset_strobes", {27'b0, rx_fifo_wr_en, parity_err, frame_err, overflow, break_det}, 32'h0);
    rst = 1'b1;
    idle(20);

    // Back-to-back good frames.
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    idle(10);

    // 0x40 has odd weight; parity bit 0 makes the frame parity odd.
    send_frame(8'h40, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'hF1, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    idle(10);

    glitch(3);
    idle(30);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    idle(10);

    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    send_frame(8'h13, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    idle(10);

    hold_low(24);
    idle(40);

    // Abort during data bit 3 (frame bit index 4), by rx_en then by reset.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b0);
    idle(20);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b1);
    idle(20);
    chk("rx_data_after_reset", {24'b0, rx_data}, 32'h0);

    send_frame(8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    idle(200);

    chk("first_write_latency", first_wr_cyc - n_first, 32'd187);
    chk("write_count", got_q.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < got_q.size())
        chk($sformatf("written_byte_%0d", i), {24'b0, got_q[i]}, {24'b0, exp_bytes[i]});
    chk("parity_err_count", n_perr, 32'd1);
    chk("overflow_count", n_ovf, 32'd1);
`ifdef UPDI_RX_BREAK_DETECT_EN
    chk("frame_err_count", n_ferr, 32'd0);
    chk("break_det_count", n_brk, 32'd1);
`else
    chk("frame_err_count", n_ferr, 32'd1);
    chk("break_det_count", n_brk, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
